// File: rtl/coin_pkg.sv
// coin_pkg: shared coin codes, emitter states and credit constants for the
// coin acceptor front end. The helper below is used by the optional running
// total (COIN_ACCEPTOR_TOTAL_EN).
package coin_pkg;

    typedef enum logic [0:0] {
        COIN_NICKEL = 1'b0,
        COIN_DIME   = 1'b1
    } coin_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } emit_state_t;

    localparam logic [7:0] NICKEL_CENTS = 8'd5;
    localparam logic [7:0] DIME_CENTS   = 8'd10;
    localparam logic [7:0] TOTAL_MAX    = 8'd255;

    // Saturating 8-bit add: clamps at TOTAL_MAX instead of wrapping.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[8]) begin
            return TOTAL_MAX;
        end else begin
            return sum[7:0];
        end
    endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if: sensor, back-pressure and strobe signals of the coin
// acceptor. The slave modport is the acceptor itself, the master modport is
// whatever drives the sensors and consumes the strobes.
// Optional macro COIN_ACCEPTOR_TOTAL_EN adds clear_total / credit_total.
interface coin_acceptor_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          nickel_sense;
    logic          dime_sense;
    logic          hold;
    logic          nickel_in;
    logic          dime_in;
    logic          coin_reject;
    logic [CW-1:0] fifo_count;
    logic          busy;
`ifdef COIN_ACCEPTOR_TOTAL_EN
    logic          clear_total;
    logic [7:0]    credit_total;
`endif

`ifdef COIN_ACCEPTOR_TOTAL_EN
    modport master (
        output nickel_sense, dime_sense, hold, clear_total,
        input  nickel_in, dime_in, coin_reject, fifo_count, busy, credit_total
    );
    modport slave (
        input  nickel_sense, dime_sense, hold, clear_total,
        output nickel_in, dime_in, coin_reject, fifo_count, busy, credit_total
    );
`else
    modport master (
        output nickel_sense, dime_sense, hold,
        input  nickel_in, dime_in, coin_reject, fifo_count, busy
    );
    modport slave (
        input  nickel_sense, dime_sense, hold,
        output nickel_in, dime_in, coin_reject, fifo_count, busy
    );
`endif

endinterface

// File: rtl/coin_debounce.sv
// coin_debounce: two-flop synchroniser, symmetric debounce counter and a
// registered one-cycle pulse on each debounced 0->1 transition (one per coin).
module coin_debounce
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sense,
    output logic level,
    output logic rise_pulse
);
    localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          meta_r;
    logic          sync_r;
    logic          level_r;
    logic          rise_r;
    logic [CW-1:0] cnt_r;
    logic          flip_s;

    // Bring the asynchronous sensor level into the clock domain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= sense;
            sync_r <= meta_r;
        end
    end

    // The level flips on the Nth consecutive sample that disagrees with it.
    always_comb begin
        flip_s = 1'b0;
        if ((sync_r != level_r) && (cnt_r == CNT_LAST)) begin
            flip_s = 1'b1;
        end else begin
            flip_s = 1'b0;
        end
    end

    // Count consecutive disagreeing samples; any agreeing sample restarts it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if ((sync_r == level_r) || flip_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Debounced level and its rising-edge pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_r <= 1'b0;
            rise_r  <= 1'b0;
        end else if (flip_s) begin
            level_r <= sync_r;
            rise_r  <= sync_r;
        end else begin
            level_r <= level_r;
            rise_r  <= 1'b0;
        end
    end

    assign level      = level_r;
    assign rise_pulse = rise_r;

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces the nickel/dime sensors, classifies each coin,
// queues it and replays it downstream as a spaced one-cycle strobe with
// hold back-pressure. Conflicting or overflowing coins are rejected.
// Optional macro COIN_ACCEPTOR_TOTAL_EN adds a saturating cents counter
// (credit_total) with a clear input (clear_total).
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_CYCLES      = 1
) (
    input  logic           clock,
    input  logic           reset_n,
    coin_acceptor_if.slave bus
);
    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam int            CW       = $clog2(FIFO_DEPTH + 1);
    localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    logic          n_level_s;
    logic          n_rise_s;
    logic          d_level_s;
    logic          d_rise_s;

    logic          push_req_s;
    coin_t         push_coin_s;
    logic          conflict_s;
    logic          accept_s;
    logic          reject_s;
    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    coin_t         head_s;
    logic [CW-1:0] count_nxt_s;

    coin_t         mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    emit_state_t   state_r;
    emit_state_t   next_state_s;
    logic [GW-1:0] gap_cnt_r;
    logic          nickel_nxt_s;
    logic          dime_nxt_s;

    logic          nickel_r;
    logic          dime_r;
    logic          reject_r;
    logic          busy_r;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel_db (
        .clock      (clock),
        .reset_n    (reset_n),
        .sense      (bus.nickel_sense),
        .level      (n_level_s),
        .rise_pulse (n_rise_s)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime_db (
        .clock      (clock),
        .reset_n    (reset_n),
        .sense      (bus.dime_sense),
        .level      (d_level_s),
        .rise_pulse (d_rise_s)
    );

    // Classify a coin event; any overlap between the two channels is a conflict.
    always_comb begin
        push_req_s  = 1'b0;
        push_coin_s = COIN_NICKEL;
        conflict_s  = 1'b0;
        if (n_rise_s && !d_rise_s && !d_level_s) begin
            push_req_s  = 1'b1;
            push_coin_s = COIN_NICKEL;
        end else if (d_rise_s && !n_rise_s && !n_level_s) begin
            push_req_s  = 1'b1;
            push_coin_s = COIN_DIME;
        end else if (n_rise_s || d_rise_s) begin
            conflict_s = 1'b1;
        end else begin
            conflict_s = 1'b0;
        end
    end

    assign empty_s = (count_r == '0);
    assign full_s  = (count_r == DEPTH_C);
    assign head_s  = mem_r[rd_ptr_r];

    // Accept a push unless full; a same-cycle pop frees the slot it needs.
    always_comb begin
        accept_s    = push_req_s && (!full_s || pop_s);
        reject_s    = conflict_s || (push_req_s && !accept_s);
        count_nxt_s = count_r;
        case ({accept_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Coin queue storage and pointers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= COIN_NICKEL;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r] <= push_coin_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_nxt_s;
        end
    end

    // Emitter state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Emitter next state: hold only matters in IDLE, a started strobe always completes.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!empty_s && !bus.hold) begin
                    next_state_s = PULSE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            PULSE: begin
                if (GAP_CYCLES > 0) begin
                    next_state_s = GAP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = GAP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Emitter outputs: pop the head on leaving IDLE and stage its strobe.
    always_comb begin
        pop_s        = 1'b0;
        nickel_nxt_s = 1'b0;
        dime_nxt_s   = 1'b0;
        if ((state_r == IDLE) && (next_state_s == PULSE)) begin
            pop_s        = 1'b1;
            nickel_nxt_s = (head_s == COIN_NICKEL);
            dime_nxt_s   = (head_s == COIN_DIME);
        end else begin
            pop_s = 1'b0;
        end
    end

    // Idle-gap counter, restarted every time a strobe is issued.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt_r <= '0;
        end else if (state_r == GAP) begin
            gap_cnt_r <= gap_cnt_r + GAP_ONE;
        end else begin
            gap_cnt_r <= '0;
        end
    end

    // Flop every outward-facing status so nothing downstream sees a glitch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            nickel_r <= 1'b0;
            dime_r   <= 1'b0;
            reject_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            nickel_r <= nickel_nxt_s;
            dime_r   <= dime_nxt_s;
            reject_r <= reject_s;
            busy_r   <= (count_nxt_s != '0) || (next_state_s != IDLE);
        end
    end

    assign bus.nickel_in   = nickel_r;
    assign bus.dime_in     = dime_r;
    assign bus.coin_reject = reject_r;
    assign bus.fifo_count  = count_r;
    assign bus.busy        = busy_r;

`ifdef COIN_ACCEPTOR_TOTAL_EN
    logic [7:0] total_r;

    // Running cents total of emitted coins; clear wins over a same-cycle add.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            total_r <= 8'd0;
        end else if (bus.clear_total) begin
            total_r <= 8'd0;
        end else if (nickel_r) begin
            total_r <= sat_add8(total_r, NICKEL_CENTS);
        end else if (dime_r) begin
            total_r <= sat_add8(total_r, DIME_CENTS);
        end else begin
            total_r <= total_r;
        end
    end

    assign bus.credit_total = total_r;
`endif

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front-end stage that feeds the per-item vending FSMs with `nickel_in` / `dime_in` strobes.
- Synchronises and debounces raw coin-sensor levels and classifies each coin.
- Queues coins in a small FIFO.
- Replays each coin as a single one-cycle strobe, with guaranteed idle spacing and a `hold` back-pressure input, so no coin is lost while the downstream FSM dispenses.
- Rejects coins on sensor conflict or queue overflow.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised samples needed to change a debounced level (min 1).
- FIFO_DEPTH, 4: coin queue entries (power of 2, min 2).
- GAP_CYCLES, 1: forced idle cycles after each output strobe (min 0).

Ports:
- clock  in  1  single system clock, all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset; one clock (`clock`), asynchronous active-low reset (`reset_n`).
- nickel_sense  in  1  raw nickel sensor level, asynchronous to `clock`.
- dime_sense  in  1  raw dime sensor level, asynchronous to `clock`.
- hold  in  1  downstream busy (tie to `dispense`); blocks new strobes.
- nickel_in  out  1  one-cycle strobe, one nickel credited downstream.
- dime_in  out  1  one-cycle strobe, one dime credited downstream.
- coin_reject  out  1  one-cycle strobe, coin refused (return chute).
- fifo_count  out  $clog2(FIFO_DEPTH+1)  queued coins not yet strobed.
- busy  out  1  high when FIFO non-empty or emitter not IDLE.

Behaviour:
- Reset (`reset_n` = 0, async): synchronisers, debounce counters, FIFO pointers and emitter state are cleared. All outputs are 0. Queued coins are discarded, including mid-strobe; no strobe appears after release until a new coin is detected.
- Synchroniser: 2 flops per sensor.
- Debounce, per channel:
  - The debounced level rises after DEBOUNCE_CYCLES consecutive synchronised 1s, and falls after DEBOUNCE_CYCLES consecutive 0s.
  - A shorter glitch is ignored and its counter restarts.
  - A coin event is the debounced 0->1 transition: exactly one event per coin, however long the sensor stays high.
- Classification, in the event cycle:
  - Nickel event alone with debounced dime low: push NICKEL.
  - Dime event alone with debounced nickel low: push DIME.
  - Both events in the same cycle, or an event while the other channel's debounced level is high: `coin_reject` = 1 next cycle, no push.
- FIFO:
  - Push when not full.
  - Push when full: `coin_reject` = 1 next cycle, coin dropped, contents unchanged.
  - Push and pop in the same cycle: both take effect, including when full (the push is accepted, count unchanged).
  - No empty bypass.
  - `fifo_count` is registered.
- Emitter FSM, states IDLE, PULSE, GAP:
  - IDLE: if FIFO non-empty and `hold` = 0, pop the head and go to PULSE; otherwise stay.
  - PULSE (1 cycle): assert the registered strobe matching the popped coin (exactly one of `nickel_in` / `dime_in`). Then go to GAP if GAP_CYCLES > 0, else IDLE.
  - GAP: count GAP_CYCLES cycles with strobes low, then go to IDLE.
  - `hold` is sampled only in IDLE; a strobe in PULSE always completes.
  - Back-to-back strobe period is GAP_CYCLES + 2 cycles.
- Latency: a push at edge E gives pop at edge E+1 and the strobe high during the cycle after E+1 (2 cycles), provided the FIFO is empty, state is IDLE and `hold` = 0.
- Outputs never glitch: `nickel_in`, `dime_in` and `coin_reject` are flop outputs.

Optional Feature:
COIN_ACCEPTOR_TOTAL_EN
- Defined:
  - Adds input `clear_total` (1) and output `credit_total` (8, cents).
  - `credit_total` adds 5 or 10 in the cycle after each emitted strobe and saturates at 255.
  - `clear_total` = 1 zeroes it, taking priority over a simultaneous add.
  - Reset value 0.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Package `coin_pkg`:
  - `coin_t` enum: COIN_NICKEL = 0, COIN_DIME = 1.
  - `emit_state_t` enum: IDLE, PULSE, GAP.
  - Constants NICKEL_CENTS = 5, DIME_CENTS = 10.
- Sub-module `coin_debounce`: synchroniser, debounce counter and rise detect, parameter DEBOUNCE_CYCLES, outputs `level` and `rise_pulse`. Instantiated once per sensor.

Test Plan:
- Hold `reset_n` low 3 cycles with sensors 0, then release -> all outputs 0, `fifo_count` = 0, `busy` = 0 for 20 cycles.
- `nickel_sense` high for 3 cycles -> no strobe. `nickel_sense` high for 10 cycles -> exactly one 1-cycle `nickel_in` pulse, 8 cycles after the sensor rise; `dime_in` stays 0.
- `hold` = 1, then five separate dimes -> `fifo_count` reaches 4 and the 5th gives one `coin_reject`. Drop `hold` -> four `dime_in` pulses exactly 3 cycles apart (GAP_CYCLES = 1), `fifo_count` ends at 0.
- `nickel_sense` and `dime_sense` rise on the same clock for 10 cycles -> one `coin_reject`, no strobe, `fifo_count` stays 0.
- Queue N, D, then assert `hold` during the N strobe cycle -> `nickel_in` pulse completes, `dime_in` withheld until 2 cycles after `hold` falls.
- 3 coins queued, pulse `reset_n` low mid-PULSE -> strobe drops immediately, `fifo_count` = 0, no strobes after release. With COIN_ACCEPTOR_TOTAL_EN: N + D + D emitted -> `credit_total` = 25; `clear_total` -> 0.
